// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
package mult_pkg;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RESW = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ARM,
    WAIT,
    SETTLE,
    DONE
  } state_e;
endpackage

// File: rtl/mult_arbiter_if.sv
// Client request/ack bus plus the shared multiplier's control/data signals.
interface mult_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import mult_pkg::*;

  logic [N_REQ-1:0]     req;
  logic [OPW*N_REQ-1:0] req_mcand;
  logic [OPW*N_REQ-1:0] req_mplier;
  logic [N_REQ-1:0]     ack;
  logic                 err;
  logic [RESW-1:0]      res;
  logic                 busy;
  logic [OPW-1:0]       mul_mcand;
  logic [OPW-1:0]       mul_mplier;
  logic                 mul_start;
  logic                 mul_finished;
  logic [RESW-1:0]      mul_result;

  modport master (
    input  req, req_mcand, req_mplier, mul_finished, mul_result,
    output ack, err, res, busy, mul_mcand, mul_mplier, mul_start
  );

  modport slave (
    output req, req_mcand, req_mplier, mul_finished, mul_result,
    input  ack, err, res, busy, mul_mcand, mul_mplier, mul_start
  );
endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, cyclically.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);
  always_comb begin
    logic [IW-1:0] c;
    c       = '0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      c = IW'((32'(ptr_i) + k) % N_REQ);
      if (!valid_o && req_i[c]) begin
        valid_o  = 1'b1;
        idx_o    = c;
        grant_o[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one 4x4 signed multiplier between N_REQ clients.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_arbiter_if.master bus
);
  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fin_q, fin_d;
  logic             err_q, err_d;
  logic [OPW-1:0]   mcand_q, mcand_d;
  logic [OPW-1:0]   mplier_q, mplier_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (rr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      gidx_q   <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d  = pick_oh;
          gidx_d = pick_idx;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
              mcand_d  = bus.req_mcand[i*OPW +: OPW];
              mplier_d = bus.req_mplier[i*OPW +: OPW];
            end
          end
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ARM;
      end
      ARM: begin
        fin_d   = bus.mul_finished;
        state_d = WAIT;
      end
      WAIT: begin
        // fin_q keeps tracking so only a fresh low->high transition completes the job
        fin_d = bus.mul_finished;
        cnt_d = cnt_q + 1'b1;
        if (bus.mul_finished && !fin_q) begin
          state_d = SETTLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      SETTLE: state_d = DONE;
      DONE: begin
        rr_d    = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ack/err/res are decoded from DONE so they read the multiplier's settled result directly
  assign bus.ack        = (state_q == DONE) ? gnt_q : '0;
  assign bus.err        = (state_q == DONE) && err_q;
  assign bus.res        = (state_q == DONE && !err_q) ? bus.mul_result : '0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.mul_start  = (state_q == LAUNCH);
  assign bus.mul_mcand  = mcand_q;
  assign bus.mul_mplier = mplier_q;
endmodule
